// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. The lookup for the fetch PC is combinational; table
//   updates from resolved branches are committed on the rising clock edge.
//
//   Optional build macro: BP_STATS_EN -- when defined, misp_count counts
//   committed mispredictions (wrapping at 16 bits); otherwise it is tied to 0
//   and no counter is built.
//
// Ports
//   clk              in   pipeline clock
//   clear            in   asynchronous active-high reset
//   en               in   update enable (IF hold); 0 freezes all state
//   PC0[31:0]        in   fetch PC to look up
//   chose_pred       out  predicted-taken hit for PC0
//   PC_pred[31:0]    out  predicted next PC for PC0
//   upd_valid        in   a resolved branch/jump is presented
//   upd_pc[31:0]     in   PC of the resolved instruction
//   upd_taken        in   resolved direction
//   upd_target[31:0] in   resolved taken target
//   upd_pred_taken   in   chose_pred that travelled with the instruction
//   upd_pred_target  in   PC_pred that travelled with the instruction
//   predict          out  resolved instruction was predicted correctly
//   misp_count[15:0] out  mispredict counter (BP_STATS_EN only, else 0)
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] PC0,
    output logic        chose_pred,
    output logic [31:0] PC_pred,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        predict,
    output logic [15:0] misp_count
);

    localparam int N     = 1 << IDX_BITS;
    localparam int TAG_W = 32 - IDX_BITS - 2;

    logic [N-1:0]                 valid_q,  valid_d;
    logic [N-1:0][TAG_W-1:0]      tag_q,    tag_d;
    logic [N-1:0][31:0]           target_q, target_d;
    logic [N-1:0][1:0]            ctr_q,    ctr_d;

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    logic                up_commit;

    // Byte offset within the instruction word never selects an entry.
    logic unused_upd_pc_lo;
    assign unused_upd_pc_lo = ^upd_pc[1:0];

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'd3) r = c + 2'd1;
        end else begin
            if (c != 2'd0) r = c - 2'd1;
        end
        return r;
    endfunction

    assign lk_idx    = PC0[IDX_BITS+1:2];
    assign lk_tag    = PC0[31:IDX_BITS+2];
    assign up_idx    = upd_pc[IDX_BITS+1:2];
    assign up_tag    = upd_pc[31:IDX_BITS+2];
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_commit = en && upd_valid;

    // Lookup reads only the registered table, so a same-cycle update to the
    // same index is not visible until the next cycle.
    always_comb begin
        chose_pred = !clear && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
        PC_pred    = chose_pred ? target_q[lk_idx] : PC0 + 32'd4;
    end

    // The target only matters for correctness when the branch was taken.
    always_comb begin
        predict = 1'b0;
        if (!clear && upd_valid) begin
            predict = (upd_pred_taken == upd_taken) &&
                      (!upd_taken || (upd_pred_target == upd_target));
        end
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (up_commit) begin
            if (up_hit) begin
                ctr_d[up_idx] = ctr_step(ctr_q[up_idx], upd_taken);
                if (upd_taken) target_d[up_idx] = upd_target;
            end else if (upd_taken) begin
                // Allocate weakly-taken so the very next lookup predicts taken.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {N{2'b01}};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] misp_q, misp_d;

    always_comb begin
        misp_d = misp_q;
        if (up_commit && !predict) misp_d = misp_q + 16'd1;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) misp_q <= '0;
        else       misp_q <= misp_d;
    end

    assign misp_count = misp_q;
`else
    assign misp_count = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed scenarios with literal expectations followed by a randomized run,
//   all checked every cycle against a behavioural table model.
module tb_branch_predictor;

    localparam int IDX_BITS = 4;
    localparam int N        = 1 << IDX_BITS;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        en;
    logic [31:0] PC0;
    logic        chose_pred;
    logic [31:0] PC_pred;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        predict;
    logic [15:0] misp_count;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
        .clk            (clk),
        .clear          (clear),
        .en             (en),
        .PC0            (PC0),
        .chose_pred     (chose_pred),
        .PC_pred        (PC_pred),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .predict        (predict),
        .misp_count     (misp_count)
    );

    // Behavioural model: each slot remembers the full PC that owns it.
    bit          m_valid [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_misp;

    int n_checks = 0;
    int n_pass   = 0;
    bit run_cmp  = 1'b0;

`ifdef BP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic bit same_owner(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDX_BITS + 2)) == (b >> (IDX_BITS + 2));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_misp = 0;
    endtask

    function automatic bit exp_hit(input logic [31:0] pc);
        int i;
        i = slot(pc);
        return !clear && m_valid[i] && same_owner(m_pc[i], pc) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] exp_next(input logic [31:0] pc);
        return exp_hit(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit exp_predict();
        if (clear || !upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b0;
        if (upd_taken && (upd_pred_target != upd_target)) return 1'b0;
        return 1'b1;
    endfunction

    // Model commit on the clock edge.
    always @(posedge clk) begin
        int i;
        if (!clear && en && upd_valid) begin
            if (!exp_predict()) m_misp = (m_misp + 1) % 65536;
            i = slot(upd_pc);
            if (m_valid[i] && same_owner(m_pc[i], upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = upd_pc;
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("chose_pred", {31'd0, chose_pred}, {31'd0, exp_hit(PC0)});
            chk("PC_pred", PC_pred, exp_next(PC0));
            chk("predict", {31'd0, predict}, {31'd0, exp_predict()});
            chk("misp_count", {16'd0, misp_count}, STATS ? m_misp : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
        upd_valid       = v;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tg;
        upd_pred_taken  = ptk;
        upd_pred_target = ptg;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] t;
        t = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) t = t + 32'h3FF0;
        return (t << (IDX_BITS + 2)) | ($urandom_range(0, N - 1) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        en  = 1'b0;
        PC0 = '0;
        set_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        m_reset();
        #2 clear = 1'b1;
        cyc();
        run_cmp = 1'b1;

        // Held in reset: outputs forced, update ignored.
        en  = 1'b1;
        PC0 = 32'h40;
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        @(negedge clk);
        chk("rst_chose", {31'd0, chose_pred}, 32'd0);
        chk("rst_pcpred", PC_pred, 32'h44);
        chk("rst_predict", {31'd0, predict}, 32'd0);
        chk("rst_misp", {16'd0, misp_count}, 32'd0);
        cyc();
        clear = 1'b0;

        // First lookup misses; taken update with no prediction allocates.
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        chk("s34_chose", {31'd0, chose_pred}, 32'd0);
        chk("s34_pcpred", PC_pred, 32'h44);
        chk("s34_predict", {31'd0, predict}, 32'd0);
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("s35_chose", {31'd0, chose_pred}, 32'd1);
        chk("s35_pcpred", PC_pred, 32'h100);

        // Not-taken update: same-cycle lookup still sees ctr=2.
        cyc();
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("s26_nobypass", {31'd0, chose_pred}, 32'd1);
        chk("s36_predict_nt", {31'd0, predict}, 32'd1);
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("s36_ctr1", {31'd0, chose_pred}, 32'd0);
        chk("s36_ctr1_pc", PC_pred, 32'h44);
        cyc();
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            @(negedge clk);
            chk("s36_ramp", {31'd0, chose_pred}, (k == 2) ? 32'd1 : 32'd0);
        end
        cyc();
        set_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        chk("s36_ctr3", {31'd0, chose_pred}, 32'd1);
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("s36_ctr3_dec", {31'd0, chose_pred}, 32'd1);

        // Conflicting tag replaces the slot.
        cyc();
        set_upd(1'b1, 32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("s37_old_chose", {31'd0, chose_pred}, 32'd0);
        chk("s37_old_pc", PC_pred, 32'h44);
        cyc();
        PC0 = 32'h440;
        @(negedge clk);
        chk("s37_new_chose", {31'd0, chose_pred}, 32'd1);
        chk("s37_new_pc", PC_pred, 32'h200);

        // Wrong target on a taken prediction.
        cyc();
        set_upd(1'b1, 32'h440, 1'b1, 32'h104, 1'b1, 32'h100);
        @(negedge clk);
        chk("s38_predict", {31'd0, predict}, 32'd0);
        cyc();
        upd_valid = 1'b0;
        @(negedge clk);
        chk("s38_misp", {16'd0, misp_count}, STATS ? 32'd3 : 32'd0);

        // Frozen update.
        cyc();
        en = 1'b0;
        set_upd(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
        cyc();
        en = 1'b1;
        upd_valid = 1'b0;
        PC0 = 32'h80;
        @(negedge clk);
        chk("s39_chose", {31'd0, chose_pred}, 32'd0);
        chk("s39_pc", PC_pred, 32'h84);
        chk("s39_misp", {16'd0, misp_count}, STATS ? 32'd3 : 32'd0);

        // PC0 + 4 wraps.
        cyc();
        PC0 = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_pc", PC_pred, 32'h0);

        // Reset lands while an update is presented: reset wins.
        cyc();
        set_upd(1'b1, 32'h44, 1'b1, 32'h500, 1'b0, 32'h0);
        #2;
        clear = 1'b1;
        m_reset();
        cyc();
        clear = 1'b0;
        upd_valid = 1'b0;
        PC0 = 32'h440;
        @(negedge clk);
        chk("midrst_old", {31'd0, chose_pred}, 32'd0);
        chk("midrst_misp", {16'd0, misp_count}, 32'd0);
        cyc();
        PC0 = 32'h44;
        @(negedge clk);
        chk("midrst_new", {31'd0, chose_pred}, 32'd0);
        chk("midrst_pc", PC_pred, 32'h48);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] tg;
            cyc();
            if (clear) clear = 1'b0;
            else if ($urandom_range(0, 299) == 0) begin
                clear = 1'b1;
                m_reset();
            end
            en  = ($urandom_range(0, 9) != 0);
            PC0 = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC : pick_pc();
            tg  = 32'h1000 + ($urandom_range(0, 3) << 2);
            upd_valid  = ($urandom_range(0, 9) < 7);
            upd_pc     = pick_pc();
            upd_taken  = 1'($urandom_range(0, 1));
            upd_target = tg;
            if ($urandom_range(0, 1) == 1) begin
                upd_pred_taken  = exp_hit(upd_pc);
                upd_pred_target = exp_next(upd_pc);
            end else begin
                upd_pred_taken  = 1'($urandom_range(0, 1));
                upd_pred_target = 32'h1000 + ($urandom_range(0, 3) << 2);
            end
        end

        cyc();
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
